// File: rtl/bus_decoder_if.sv
// Arbiter-facing request/response port and shared device-side request bus of the decoder.
interface bus_decoder_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEV_NUMS = 4
);
    localparam int unsigned BE_W = XLEN / 8;

    logic                S_strobe_i;
    logic [XLEN-1:0]     S_addr_i;
    logic                S_rw_i;
    logic [BE_W-1:0]     S_byte_enable_i;
    logic [XLEN-1:0]     S_data_i;
    logic                S_data_ready_o;
    logic [XLEN-1:0]     S_data_o;

    logic [DEV_NUMS-1:0] D_strobe_o;
    logic [XLEN-1:0]     D_addr_o;
    logic                D_rw_o;
    logic [BE_W-1:0]     D_byte_enable_o;
    logic [XLEN-1:0]     D_data_o;
    logic [DEV_NUMS-1:0] D_data_ready_i;
    logic [XLEN-1:0]     D_data_i [DEV_NUMS];

    logic                bus_err_o;
    logic [1:0]          err_code_o;
    logic [XLEN-1:0]     err_addr_o;

    modport slave (
        input  S_strobe_i, S_addr_i, S_rw_i, S_byte_enable_i, S_data_i,
        output S_data_ready_o, S_data_o,
        output D_strobe_o, D_addr_o, D_rw_o, D_byte_enable_o, D_data_o,
        input  D_data_ready_i, D_data_i,
        output bus_err_o, err_code_o, err_addr_o
    );

    modport master (
        output S_strobe_i, S_addr_i, S_rw_i, S_byte_enable_i, S_data_i,
        input  S_data_ready_o, S_data_o,
        input  D_strobe_o, D_addr_o, D_rw_o, D_byte_enable_o, D_data_o,
        output D_data_ready_i, D_data_i,
        input  bus_err_o, err_code_o, err_addr_o
    );
endinterface

// File: rtl/bus_decoder.sv
// Single-outstanding bus responder: decodes the address region, strobes one device,
// and returns its reply or an unmapped/timeout error as a registered one-cycle response.
module bus_decoder #(
    parameter int unsigned      XLEN           = 32,
    parameter int unsigned      DEV_NUMS       = 4,
    parameter logic [3:0]       REGION_BASE    = 4'hC,
    parameter int unsigned      TIMEOUT_CYCLES = 1024,
    parameter logic [XLEN-1:0]  ERR_DATA       = '1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    bus_decoder_if.slave bus
);
    localparam int unsigned BE_W  = XLEN / 8;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] ERR_UNMAPPED = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic                rw_q, rw_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [DEV_NUMS-1:0] strobe_q, strobe_d;
    logic                rdy_q, rdy_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic                berr_q, berr_d;
    logic [1:0]          ecode_q, ecode_d;
    logic [XLEN-1:0]     eaddr_q, eaddr_d;

    logic [SEL_W-1:0]    diff_c;
    logic                mapped_c;
    logic                dev_ready_c;
    logic [XLEN-1:0]     dev_data_c;

    // Region decode wraps modulo 16 so bases near the top of the map still work.
    assign diff_c   = SEL_W'(bus.S_addr_i[XLEN-1 -: SEL_W] - REGION_BASE);
    assign mapped_c = ({1'b0, diff_c} < (SEL_W+1)'(DEV_NUMS));

    always_comb begin
        dev_ready_c = 1'b0;
        dev_data_c  = '0;
        for (int i = 0; i < int'(DEV_NUMS); i++) begin
            if (sel_q == SEL_W'(i)) begin
                dev_ready_c = bus.D_data_ready_i[i];
                dev_data_c  = bus.D_data_i[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            strobe_q <= '0;
            rdy_q    <= 1'b0;
            rdata_q  <= '0;
            berr_q   <= 1'b0;
            ecode_q  <= '0;
            eaddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            strobe_q <= strobe_d;
            rdy_q    <= rdy_d;
            rdata_q  <= rdata_d;
            berr_q   <= berr_d;
            ecode_q  <= ecode_d;
            eaddr_q  <= eaddr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        strobe_d = '0;
        rdy_d    = 1'b0;
        rdata_d  = rdata_q;
        berr_d   = 1'b0;
        ecode_d  = ecode_q;
        eaddr_d  = eaddr_q;

        unique case (state_q)
            IDLE: begin
                if (bus.S_strobe_i) begin
                    addr_d  = bus.S_addr_i;
                    rw_d    = bus.S_rw_i;
                    be_d    = bus.S_byte_enable_i;
                    wdata_d = bus.S_data_i;
                    sel_d   = diff_c;
                    if (mapped_c) begin
                        state_d = ISSUE;
                        for (int i = 0; i < int'(DEV_NUMS); i++) begin
                            strobe_d[i] = (diff_c == SEL_W'(i));
                        end
                    end else begin
                        state_d = RESP;
                        rdy_d   = 1'b1;
                        rdata_d = ERR_DATA;
                        berr_d  = 1'b1;
                        ecode_d = ERR_UNMAPPED;
                        eaddr_d = bus.S_addr_i;
                    end
                end
            end
            ISSUE: begin
                cnt_d = '0;
                if (dev_ready_c) begin
                    state_d = RESP;
                    rdy_d   = 1'b1;
                    rdata_d = dev_data_c;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Device ready takes priority over a timeout expiring in the same cycle.
                if (dev_ready_c) begin
                    state_d = RESP;
                    rdy_d   = 1'b1;
                    rdata_d = dev_data_c;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2)) begin
                    state_d = RESP;
                    rdy_d   = 1'b1;
                    rdata_d = ERR_DATA;
                    berr_d  = 1'b1;
                    ecode_d = ERR_TIMEOUT;
                    eaddr_d = addr_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.S_data_ready_o  = rdy_q;
    assign bus.S_data_o        = rdata_q;
    assign bus.D_strobe_o      = strobe_q;
    assign bus.D_addr_o        = addr_q;
    assign bus.D_rw_o          = rw_q;
    assign bus.D_byte_enable_o = be_q;
    assign bus.D_data_o        = wdata_q;
    assign bus.bus_err_o       = berr_q;
    assign bus.err_code_o      = ecode_q;
    assign bus.err_addr_o      = eaddr_q;

endmodule
